fpu_lzd_norm_pipe: RTL and testbench



---
 rtl/fpu_lzd_pkg.sv | 43 ++++
 rtl/fpu_lzd_norm_pipe_seg.sv | 17 +
 rtl/fpu_lzd_norm_pipe.sv | 127 ++++++++++++
 tb/tb_fpu_lzd_norm_pipe.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fpu_lzd_pkg.sv
// Shared definitions for the FPU leading-zero detector / normaliser:
// format modes, field widths and the per-mode offset lookup.
package fpu_lzd_pkg;

    typedef enum logic [2:0] {
        MODE_DP   = 3'd0,
        MODE_SP   = 3'd1,
        MODE_HP   = 3'd2,
        MODE_BF16 = 3'd3,
        MODE_I2F  = 3'd4
    } mode_e;

    localparam int FW_DP   = 32'd53;
    localparam int FW_SP   = 32'd24;
    localparam int FW_HP   = 32'd11;
    localparam int FW_BF16 = 32'd8;
    localparam int FW_I2F  = 32'd32;

    typedef struct packed {
        logic [7:0] offset;
        logic [7:0] field;
        logic       illegal;
    } mode_info_t;

    // A mode is illegal when it is unassigned or its field does not fit in the datapath.
    function automatic mode_info_t mode_offset(input logic [2:0] mode, input int w);
        mode_info_t info;
        int         fw;
        case (mode)
            MODE_DP:   fw = FW_DP;
            MODE_SP:   fw = FW_SP;
            MODE_HP:   fw = FW_HP;
            MODE_BF16: fw = FW_BF16;
            MODE_I2F:  fw = FW_I2F;
            default:   fw = 32'd0;
        endcase
        info.illegal = (fw == 32'd0) || (fw > w);
        info.field   = info.illegal ? 8'd0 : 8'(fw);
        info.offset  = info.illegal ? 8'd0 : 8'(w - fw);
        return info;
    endfunction

endpackage

// File: rtl/fpu_lzd_norm_pipe_seg.sv
// Combinational leading-zero count of one 16-bit segment.
module fpu_lzc_seg (
    input  logic [15:0] i_data,
    output logic [3:0]  o_cnt,
    output logic        o_zero
);

    // Highest set bit wins; the scan runs upward so later hits override.
    always_comb begin
        o_cnt = 4'd0;
        for (int i = 0; i < 16; i++) begin
            o_cnt = i_data[i] ? 4'(15 - i) : o_cnt;
        end
        o_zero = (i_data == 16'd0);
    end

endmodule

// File: rtl/fpu_lzd_norm_pipe.sv
// Three-stage elastic leading-zero detector and left normaliser shared by
// all FPU result formats: mask -> count/adjust -> shift.
module fpu_lzd_norm_pipe #(
    parameter  int W  = 64,
    localparam int CW = $clog2(W) + 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_in_valid,
    output logic          o_in_ready,
    input  logic [2:0]    i_in_mode,
    input  logic [W-1:0]  i_in_data,
    output logic          o_out_valid,
    input  logic          i_out_ready,
    output logic [CW-1:0] o_out_lzc,
    output logic [7:0]    o_out_adj,
    output logic [W-1:0]  o_out_norm,
    output logic          o_out_zero,
    output logic          o_out_err
);
    import fpu_lzd_pkg::*;

    localparam int NSEG = W / 16;

    logic            r1_valid, r2_valid, r3_valid;
    logic [W-1:0]    r1_data, r2_data, r3_norm;
    logic [7:0]      r1_off, r2_adj, r3_adj;
    logic            r1_err, r2_err, r3_err;
    logic            r2_zero, r3_zero;
    logic [CW-1:0]   r2_lzc, r3_lzc;

    logic            w_ready1, w_ready2, w_ready3;
    mode_info_t      w_info;
    logic [W-1:0]    w_mask;
    logic [3:0]      w_seg_cnt [NSEG];
    logic [NSEG-1:0] w_seg_zero;
    logic [CW-1:0]   w_lzc;
    logic [7:0]      w_adj;
    logic            w_zero;

    assign w_ready3   = !r3_valid | i_out_ready;
    assign w_ready2   = !r2_valid | w_ready3;
    assign w_ready1   = !r1_valid | w_ready2;
    assign o_in_ready = w_ready1 & !i_rst;

    assign w_info = mode_offset(i_in_mode, W);
    assign w_mask = w_info.illegal ? {W{1'b0}} : ~({W{1'b1}} << w_info.field);

    // S1: capture the masked operand with its offset and error flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r1_valid <= 1'b0;
            r1_data  <= {W{1'b0}};
            r1_off   <= 8'd0;
            r1_err   <= 1'b0;
        end else if (w_ready1) begin
            r1_valid <= i_in_valid;
            r1_data  <= i_in_data & w_mask;
            r1_off   <= w_info.offset;
            r1_err   <= w_info.illegal;
        end
    end

    for (genvar g = 0; g < NSEG; g++) begin : g_seg
        fpu_lzc_seg u_seg (
            .i_data (r1_data[16*g +: 16]),
            .o_cnt  (w_seg_cnt[g]),
            .o_zero (w_seg_zero[g])
        );
    end

    // The most significant non-empty segment determines the count.
    always_comb begin
        w_lzc = {CW{1'b0}};
        for (int i = 0; i < NSEG; i++) begin
            w_lzc = w_seg_zero[i] ? w_lzc : CW'((NSEG - 1 - i) * 16) + CW'(w_seg_cnt[i]);
        end
        w_zero = (&w_seg_zero) | r1_err;
        w_adj  = w_zero ? 8'd0 : 8'(w_lzc) - r1_off;
    end

    // S2: count and exponent adjustment.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r2_valid <= 1'b0;
            r2_data  <= {W{1'b0}};
            r2_lzc   <= {CW{1'b0}};
            r2_adj   <= 8'd0;
            r2_zero  <= 1'b0;
            r2_err   <= 1'b0;
        end else if (w_ready2) begin
            r2_valid <= r1_valid;
            r2_data  <= w_zero ? {W{1'b0}} : r1_data;
            r2_lzc   <= w_zero ? {CW{1'b0}} : w_lzc;
            r2_adj   <= w_adj;
            r2_zero  <= w_zero;
            r2_err   <= r1_err;
        end
    end

    // S3: barrel shift into the output registers; holds while stalled.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r3_valid <= 1'b0;
            r3_norm  <= {W{1'b0}};
            r3_lzc   <= {CW{1'b0}};
            r3_adj   <= 8'd0;
            r3_zero  <= 1'b0;
            r3_err   <= 1'b0;
        end else if (w_ready3) begin
            r3_valid <= r2_valid;
            r3_norm  <= r2_data << r2_lzc;
            r3_lzc   <= r2_lzc;
            r3_adj   <= r2_adj;
            r3_zero  <= r2_zero;
            r3_err   <= r2_err;
        end
    end

    assign o_out_valid = r3_valid;
    assign o_out_norm  = r3_norm;
    assign o_out_lzc   = r3_lzc;
    assign o_out_adj   = r3_adj;
    assign o_out_zero  = r3_zero;
    assign o_out_err   = r3_err;

endmodule

// File: tb/tb_fpu_lzd_norm_pipe.sv
// Directed bench for fpu_lzd_norm_pipe (W=64) with an in-order expectation queue.
module tb_fpu_lzd_norm_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_mode = 3'd0;
    logic [63:0] in_data = 64'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [6:0]  out_lzc;
    logic [7:0]  out_adj;
    logic [63:0] out_norm;
    logic        out_zero;
    logic        out_err;

    typedef struct {
        logic [2:0]  mode;
        logic [63:0] data;
        logic [63:0] lzc;
        logic [63:0] adj;
        logic [63:0] norm;
        logic [63:0] zero;
        logic [63:0] err;
    } tv_t;

    tv_t tv [13];
    int  exp_q [$];
    int  drv_idx = 0;
    int  n_cmp = 0;
    int  n_err = 0;

    fpu_lzd_norm_pipe #(.W(64)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_mode   (in_mode),
        .i_in_data   (in_data),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_lzc   (out_lzc),
        .o_out_adj   (out_adj),
        .o_out_norm  (out_norm),
        .o_out_zero  (out_zero),
        .o_out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic init_tv();
        tv[0]  = '{3'd1, 64'h0000_0000_0080_0000, 64'd40, 64'd0,  64'h8000_0000_0000_0000, 64'd0, 64'd0};
        tv[1]  = '{3'd0, 64'h0000_0000_0000_0001, 64'd63, 64'd52, 64'h8000_0000_0000_0000, 64'd0, 64'd0};
        tv[2]  = '{3'd1, 64'h0000_0100_0000_0001, 64'd63, 64'd23, 64'h8000_0000_0000_0000, 64'd0, 64'd0};
        tv[3]  = '{3'd6, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,  64'd0,  64'h0,                   64'd1, 64'd1};
        tv[4]  = '{3'd2, 64'h0000_0000_0000_0000, 64'd0,  64'd0,  64'h0,                   64'd1, 64'd0};
        tv[5]  = '{3'd3, 64'h0000_0000_0000_00FF, 64'd56, 64'd0,  64'hFF00_0000_0000_0000, 64'd0, 64'd0};
        tv[6]  = '{3'd4, 64'h0000_0000_0001_0000, 64'd47, 64'd15, 64'h8000_0000_0000_0000, 64'd0, 64'd0};
        tv[7]  = '{3'd2, 64'h0000_0000_0000_0405, 64'd53, 64'd0,  64'h80A0_0000_0000_0000, 64'd0, 64'd0};
        tv[8]  = '{3'd0, 64'hFFF0_0000_0000_0003, 64'd11, 64'd0,  64'h8000_0000_0000_1800, 64'd0, 64'd0};
        tv[9]  = '{3'd1, 64'h0000_0000_0000_1234, 64'd51, 64'd11, 64'h91A0_0000_0000_0000, 64'd0, 64'd0};
        tv[10] = '{3'd5, 64'h0000_0000_0000_1234, 64'd0,  64'd0,  64'h0,                   64'd1, 64'd1};
        tv[11] = '{3'd4, 64'hFFFF_FFFF_8000_0000, 64'd32, 64'd0,  64'h8000_0000_0000_0000, 64'd0, 64'd0};
        tv[12] = '{3'd7, 64'h0000_0000_0000_0000, 64'd0,  64'd0,  64'h0,                   64'd1, 64'd1};
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input int idx);
        bit acc;
        in_valid = 1'b1;
        in_mode  = tv[idx].mode;
        in_data  = tv[idx].data;
        drv_idx  = idx;
        acc      = 1'b0;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        chk_eq($sformatf("accept[%0d]", idx), 64'(acc), 64'd1);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_mode  = 3'd6;
        in_data  = 64'hDEAD_BEEF_0BAD_F00D;
    endtask

    task automatic drain();
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        chk_eq("drain", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Output monitor: head of the queue must be on the outputs whenever valid.
    always @(negedge clk) begin
        int h;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (exp_q.size() == 0) begin
                chk_eq("stray_out_valid", 64'(out_valid), 64'd0);
            end else if (out_valid) begin
                h = exp_q[0];
                chk_eq($sformatf("lzc[%0d]", h),  64'(out_lzc),  tv[h].lzc);
                chk_eq($sformatf("adj[%0d]", h),  64'(out_adj),  tv[h].adj);
                chk_eq($sformatf("norm[%0d]", h), out_norm,      tv[h].norm);
                chk_eq($sformatf("zero[%0d]", h), 64'(out_zero), tv[h].zero);
                chk_eq($sformatf("err[%0d]", h),  64'(out_err),  tv[h].err);
                if (out_ready) void'(exp_q.pop_front());
            end
            if (in_valid && in_ready) exp_q.push_back(drv_idx);
        end
    end

    initial begin
        int lat;
        init_tv();
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_eq("rst_out_valid", 64'(out_valid), 64'd0);
        chk_eq("rst_in_ready",  64'(in_ready),  64'd0);
        chk_eq("rst_lzc",       64'(out_lzc),   64'd0);
        chk_eq("rst_adj",       64'(out_adj),   64'd0);
        chk_eq("rst_norm",      out_norm,       64'd0);
        chk_eq("rst_zero",      64'(out_zero),  64'd0);
        chk_eq("rst_err",       64'(out_err),   64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_eq("in_ready_after_rst", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        send(0);
        idle();
        lat = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        chk_eq("latency", 64'(lat), 64'd3);
        @(posedge clk);
        #1;
        drain();

        for (int i = 1; i <= 4; i++) send(i);
        idle();
        drain();

        fork
            begin
                for (int i = 5; i <= 12; i++) send(i);
                idle();
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                @(negedge clk);
                chk_eq("in_ready_full", 64'(in_ready), 64'd0);
                chk_eq("buffered", 64'(exp_q.size()), 64'd3);
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        send(0);
        send(1);
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_eq("post_rst_out_valid", 64'(out_valid), 64'd0);
        chk_eq("post_rst_in_ready",  64'(in_ready),  64'd1);
        repeat (6) @(negedge clk);
        @(posedge clk);
        #1;

        send(9);
        idle();
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
